// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter FSM and the receiver.
//   - tx_state_t        : transmit FSM state encoding
//   - *_DEFAULT         : default oversample ratio and data width
//   - FRAME_BITS        : start + 8 data + parity + stop
//   - START_BIT / STOP_BIT / IDLE_LEVEL : line levels
//   - parity_of()       : parity bit for a data word
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT  = 8;
    localparam int FRAME_BITS         = 11;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Caller zero-extends the data word; unused upper bits do not affect the XOR.
    function automatic logic parity_of(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_transmitter_fsm_if.sv
// -----------------------------------------------------------------------------
// uart_transmitter_fsm_if
// Byte-source handshake plus TX line/status of the UART transmitter.
//   dataIn/dataValid : byte offered by the source (master drives)
//   dataReady        : transmitter can take a byte
//   serialOutput     : TX line, idles high
//   busy / txDone    : frame in progress / end-of-frame pulse
// Modports: master = byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_transmitter_fsm_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
);
    logic [DATA_BITS-1:0] dataIn;
    logic                 dataValid;
    logic                 dataReady;
    logic                 serialOutput;
    logic                 busy;
    logic                 txDone;

    modport master (
        output dataIn, dataValid,
        input  dataReady, serialOutput, busy, txDone
    );

    modport slave (
        input  dataIn, dataValid,
        output dataReady, serialOutput, busy, txDone
    );
endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts oversampled clock cycles inside one bit-time (0..OVERSAMPLE-1).
//   clk    : oversampled baud clock
//   rst    : synchronous active-high reset
//   clear  : hold the counter at 0 (e.g. while the line is idle)
//   bitEnd : high during the last cycle of a bit-time (tick == OVERSAMPLE-1)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bitEnd
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [TW-1:0] tick_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick_reg <= '0;
        end else if (bitEnd) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + TW'(1);
        end
    end

    assign bitEnd = !clear && (tick_reg == TW'(OVERSAMPLE - 1));
endmodule

// File: rtl/uart_transmitter_fsm.sv
// -----------------------------------------------------------------------------
// uart_transmitter_fsm
// Serialises one byte per frame: start(0), d0..d7 LSB first, parity, stop(1).
//   baudRateOut : 16x oversampled baud clock, rising edge
//   rst         : synchronous active-high reset
//   tx (slave)  : dataIn/dataValid/dataReady handshake, serialOutput, busy,
//                 txDone (pulse on the last cycle of the stop bit)
// Optional feature macro UART_TX_HOLD_REG_EN: one-deep holding register so a
// byte can be accepted mid-frame and frames run back-to-back with no gap.
// serialOutput is registered from the state, so the line lags the state by one
// cycle: accept at edge N gives start bit from N+1 and txDone at N+176.
// -----------------------------------------------------------------------------
module uart_transmitter_fsm
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int PARITY_ODD = 1
) (
    input logic                   baudRateOut,
    input logic                   rst,
    uart_transmitter_fsm_if.slave tx
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t            state_reg;
    logic [BW-1:0]        bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 serial_reg;
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic accept;
    logic bit_end;
    logic par_in;

    assign accept = tx.dataValid && ready_reg;
    assign par_in = parity_of(32'(tx.dataIn), 1'(PARITY_ODD));

`ifdef UART_TX_HOLD_REG_EN
    logic [DATA_BITS-1:0] hold_data_reg;
    logic                 hold_par_reg;
    logic                 hold_full_reg;
    logic                 stop_end;
    logic                 drain;
    logic                 to_hold;

    assign stop_end = (state_reg == STOP) && bit_end;
    assign drain    = stop_end && hold_full_reg;
    // A byte arriving at the stop-bit end with an empty hold register starts
    // the next frame directly instead of being parked in the hold register.
    assign to_hold  = accept && (state_reg != IDLE) && !(stop_end && !hold_full_reg);
`endif

    // Tick counter is frozen at 0 in IDLE so START always gets a full bit-time.
    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk   (baudRateOut),
        .rst   (rst),
        .clear (state_reg == IDLE),
        .bitEnd(bit_end)
    );

    always_ff @(posedge baudRateOut) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            serial_reg  <= IDLE_LEVEL;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
            hold_data_reg <= '0;
            hold_par_reg  <= 1'b0;
            hold_full_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;

            // Line level follows the current state one cycle later.
            case (state_reg)
                IDLE:    serial_reg <= IDLE_LEVEL;
                START:   serial_reg <= START_BIT;
                DATA:    serial_reg <= shift_reg[0];
                PARITY:  serial_reg <= parity_reg;
                default: serial_reg <= STOP_BIT;
            endcase

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg  <= START;
                        shift_reg  <= tx.dataIn;
                        parity_reg <= par_in;
                        busy_reg   <= 1'b1;
`ifndef UART_TX_HOLD_REG_EN
                        ready_reg  <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (bit_end) state_reg <= DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx_reg == BW'(DATA_BITS - 1)) begin
                            bit_idx_reg <= '0;
                            state_reg   <= PARITY;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) state_reg <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        done_reg <= 1'b1;
`ifdef UART_TX_HOLD_REG_EN
                        if (hold_full_reg) begin
                            state_reg  <= START;
                            shift_reg  <= hold_data_reg;
                            parity_reg <= hold_par_reg;
                        end else if (accept) begin
                            state_reg  <= START;
                            shift_reg  <= tx.dataIn;
                            parity_reg <= par_in;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
`else
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase

`ifdef UART_TX_HOLD_REG_EN
            // Fill wins over drain so an accept on the drain edge refills the slot.
            if (to_hold) begin
                hold_data_reg <= tx.dataIn;
                hold_par_reg  <= par_in;
                hold_full_reg <= 1'b1;
                ready_reg     <= 1'b0;
            end else if (drain) begin
                hold_full_reg <= 1'b0;
                ready_reg     <= 1'b1;
            end
`endif
        end
    end

    assign tx.serialOutput = serial_reg;
    assign tx.dataReady    = ready_reg;
    assign tx.busy         = busy_reg;
    assign tx.txDone       = done_reg;
endmodule

// File: tb/tb_uart_transmitter_fsm.sv
`timescale 1ns/1ps
module tb_uart_transmitter_fsm;
    logic clk;
    logic rst;
    int   cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    int         acc_q[$];
    bit         mon_en   = 1'b1;
    bit         mon_busy = 1'b0;

`ifdef UART_TX_HOLD_REG_EN
    localparam int GAP       = 0;
    localparam int B2B_DELTA = 1;
`else
    localparam int GAP       = 1;
    localparam int B2B_DELTA = 177;
`endif

    uart_transmitter_fsm_if bus ();
    uart_transmitter_fsm_if bus2 ();

    uart_transmitter_fsm u_dut (
        .baudRateOut(clk),
        .rst        (rst),
        .tx         (bus)
    );

    uart_transmitter_fsm #(
        .PARITY_ODD(0)
    ) u_dut_even (
        .baudRateOut(clk),
        .rst        (rst),
        .tx         (bus2)
    );

    initial clk = 1'b0;
    always begin
        #13020 clk = 1'b1;
        #13021 clk = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge. Returns the posedge number on which the byte was taken.
    task automatic send_byte(input logic [7:0] d, input logic par, input bit track, output int acc);
        bus.dataIn    = d;
        bus.dataValid = 1'b1;
        acc = -1;
        for (int k = 0; k < 1000 && acc < 0; k++) begin
            if (bus.dataReady === 1'b1) acc = cyc + 1;
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", 1, 0);
        end else if (track) begin
            exp_q.push_back({par, d});
            acc_q.push_back(acc);
        end
        $display("send 0x%02h accepted at edge %0d", d, acc);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || mon_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("wait_idle_timeout", k, 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: captures each frame cycle by cycle and scores it against the queue.
    initial begin : monitor
        logic       line_buf [0:175];
        logic [10:0] frame;
        logic [8:0] exp_word;
        logic [8:0] got_word;
        int start_cyc, acc_cyc, exp_start, prev_start;
        int bit_bad, busy_bad, done_bad, frame_no;
        prev_start = -100000;
        frame_no   = 0;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b0 && bus.serialOutput === 1'b0) begin
                mon_busy  = 1'b1;
                start_cyc = cyc;
                busy_bad  = 0;
                done_bad  = 0;
                for (int c = 0; c < 176; c++) begin
                    if (c > 0) @(negedge clk);
                    line_buf[c] = bus.serialOutput;
                    if (c < 175 && bus.busy !== 1'b1) busy_bad++;
                    if (bus.txDone !== (c == 175)) done_bad++;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    acc_cyc  = acc_q.pop_front();
                    frame    = {1'b1, exp_word, 1'b0};
                    bit_bad  = 0;
                    for (int c = 0; c < 176; c++)
                        if (line_buf[c] !== frame[c / 16]) bit_bad++;
                    for (int i = 0; i < 9; i++)
                        got_word[i] = line_buf[16 * (i + 1) + 8];
                    exp_start = (acc_cyc + 1 > prev_start + 176 + GAP) ? acc_cyc + 1
                                                                        : prev_start + 176 + GAP;
                    $display("frame %0d: start %0d got 9'h%03h exp 9'h%03h", frame_no,
                             start_cyc, got_word, exp_word);
                    check("frame_start_cycle", start_cyc, exp_start);
                    check("line_bad_cycles", bit_bad, 0);
                    check("decoded_word", got_word, exp_word);
                    check("busy_low_cycles", busy_bad, 0);
                    check("txdone_bad_cycles", done_bad, 0);
                end
                prev_start = start_cyc;
                frame_no++;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int a1, a2, acc2, done_seen, line_low;
        rst            = 1'b1;
        bus.dataIn     = 8'h77;
        bus.dataValid  = 1'b1;
        bus2.dataIn    = 8'h00;
        bus2.dataValid = 1'b0;

        // Reset held with a valid byte offered.
        repeat (3) @(negedge clk);
        check("rst_serialOutput", bus.serialOutput, 1);
        check("rst_dataReady", bus.dataReady, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_txDone", bus.txDone, 0);
        rst           = 1'b0;
        bus.dataValid = 1'b0;
        @(negedge clk);
        check("no_accept_in_reset_busy", bus.busy, 0);
        check("no_accept_in_reset_line", bus.serialOutput, 1);

        // Single frames with hand-computed odd parity.
        send_byte(8'h55, 1'b1, 1'b1, a1); bus.dataValid = 1'b0; wait_idle();
        send_byte(8'h00, 1'b1, 1'b1, a1); bus.dataValid = 1'b0; wait_idle();
        send_byte(8'hFF, 1'b1, 1'b1, a1); bus.dataValid = 1'b0; wait_idle();
        send_byte(8'h01, 1'b0, 1'b1, a1); bus.dataValid = 1'b0; wait_idle();
        send_byte(8'hC3, 1'b1, 1'b1, a1); bus.dataValid = 1'b0; wait_idle();

        // Back-to-back with dataValid held high.
        send_byte(8'hA5, 1'b1, 1'b1, a1);
        send_byte(8'h3C, 1'b1, 1'b1, a2);
        bus.dataValid = 1'b0;
        check("b2b_second_accept_delta", a2 - a1, B2B_DELTA);
        wait_idle();

        // Reset during DATA bit 3 of 0x0F.
        mon_en = 1'b0;
        send_byte(8'h0F, 1'b1, 1'b0, a1);
        bus.dataValid = 1'b0;
        repeat (70) @(negedge clk);
        check("mid_frame_d3_level", bus.serialOutput, 1);
        check("mid_frame_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_serialOutput", bus.serialOutput, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_dataReady", bus.dataReady, 1);
        check("abort_txDone", bus.txDone, 0);
        done_seen = 0;
        line_low  = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.txDone === 1'b1) done_seen++;
            if (bus.serialOutput !== 1'b1) line_low++;
        end
        check("abort_no_txDone", done_seen, 0);
        check("abort_line_idle", line_low, 0);
        mon_en = 1'b1;

        // Even-parity instance: 0x01 -> parity bit 1.
        bus2.dataIn    = 8'h01;
        bus2.dataValid = 1'b1;
        acc2 = -1;
        for (int k = 0; k < 100 && acc2 < 0; k++) begin
            if (bus2.dataReady === 1'b1) acc2 = cyc + 1;
            @(negedge clk);
        end
        bus2.dataValid = 1'b0;
        if (acc2 < 0) begin
            check("even_accept_timeout", 1, 0);
        end else begin
            $display("send 0x01 (even parity) accepted at edge %0d", acc2);
            repeat (25) @(negedge clk);
            check("even_d0_level", bus2.serialOutput, 1);
            repeat (128) @(negedge clk);
            check("even_parity_bit", bus2.serialOutput, 1);
        end
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
